// File: rtl/execute_stage_pkg.sv
// Shared constants for the execute stage: datapath width, ALU op codes, forwarding selects.
// Also defines the EX/MEM control bundle carried alongside a result or a pending multiply.
package execute_stage_pkg;

   localparam int DEF_WORD_SIZE = 32;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLT = 4'b0101;
   localparam logic [3:0] ALU_SLL = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1000;
   localparam logic [3:0] ALU_MUL = 4'b1001;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic [4:0] rd;
      logic       regWrite;
      logic       memWrite;
      logic       byteAddress;
      logic       readEnable;
      logic [1:0] resultSrc;
   } exCtrl_t;

   localparam int EX_CTRL_W = $bits(exCtrl_t);

endpackage

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier, MUL_STEP multiplier bits per cycle; product ready
// WORD_SIZE/MUL_STEP+1 edges after start. Counting ignores stall; DONE holds until stall drops.
module mul_unit
   import execute_stage_pkg::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int MUL_STEP  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 isMul,
   input  logic                 flush,
   input  logic                 stall,
   input  logic [WORD_SIZE-1:0] srcA,
   input  logic [WORD_SIZE-1:0] srcB,
   input  logic [WORD_SIZE-1:0] writeDataIn,
   input  logic [WORD_SIZE-1:0] pcPlus4In,
   input  logic [EX_CTRL_W-1:0] ctrlIn,
   output logic                 busy,
   output logic                 wrProduct,
   output logic [WORD_SIZE-1:0] product,
   output logic [WORD_SIZE-1:0] writeDataOut,
   output logic [WORD_SIZE-1:0] pcPlus4Out,
   output logic [EX_CTRL_W-1:0] ctrlOut
);

   localparam int STEPS = WORD_SIZE / MUL_STEP;
   localparam int CNT_W = $clog2(STEPS + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]           state;
   logic [CNT_W-1:0]     count;
   logic [WORD_SIZE-1:0] mcand;
   logic [WORD_SIZE-1:0] mplier;
   logic [WORD_SIZE-1:0] acc;
   logic [WORD_SIZE-1:0] partial;
   logic                 start;

   assign start     = (state == IDLE) && isMul && !flush && !stall;
   // mcand is pre-shifted each cycle, so the truncated product lands at the right weight
   assign partial   = mcand * WORD_SIZE'(mplier[MUL_STEP-1:0]);
   assign busy      = ((state == IDLE) && isMul) || (state == RUN) || ((state == DONE) && stall);
   assign wrProduct = (state == DONE) && !stall;
   assign product   = acc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         count        <= '0;
         mcand        <= '0;
         mplier       <= '0;
         acc          <= '0;
         writeDataOut <= '0;
         pcPlus4Out   <= '0;
         ctrlOut      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state        <= RUN;
                  mcand        <= srcA;
                  mplier       <= srcB;
                  acc          <= '0;
                  count        <= CNT_W'(STEPS);
                  writeDataOut <= writeDataIn;
                  pcPlus4Out   <= pcPlus4In;
                  ctrlOut      <= ctrlIn;
               end
            end
            RUN: begin
               acc    <= acc + partial;
               mcand  <= mcand << MUL_STEP;
               mplier <= mplier >> MUL_STEP;
               count  <= count - CNT_W'(1);
               if (count == CNT_W'(1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (!stall) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: forwarding muxes, ALU, branch resolve and EX/MEM register (1 edge; MUL 6 edges).
// StallM freezes EX/MEM and beats FlushE; MulBusy asks the hazard unit to hold F/D/E.
module execute_stage
   import execute_stage_pkg::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int MUL_STEP  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WORD_SIZE-1:0] RD1E,
   input  logic [WORD_SIZE-1:0] RD2E,
   input  logic [WORD_SIZE-1:0] ImmExtE,
   input  logic [WORD_SIZE-1:0] PCE,
   input  logic [WORD_SIZE-1:0] PCPlus4E,
   input  logic [4:0]           RdE,
   input  logic [3:0]           ALUControlE,
   input  logic                 ALUSrcE,
   input  logic                 RegWriteE,
   input  logic                 MemWriteE,
   input  logic                 JumpE,
   input  logic                 BranchE,
   input  logic                 ByteAddressE,
   input  logic                 ReadEnableE,
   input  logic [1:0]           ResultSrcE,
   input  logic [1:0]           ForwardAE,
   input  logic [1:0]           ForwardBE,
   input  logic [WORD_SIZE-1:0] ResultW,
   input  logic                 StallM,
   input  logic                 FlushE,
   output logic [WORD_SIZE-1:0] ALUResultM,
   output logic [WORD_SIZE-1:0] WriteDataM,
   output logic [WORD_SIZE-1:0] PCPlus4M,
   output logic [4:0]           RdM,
   output logic                 RegWriteM,
   output logic                 MemWriteM,
   output logic                 ByteAddressM,
   output logic                 ReadEnableM,
   output logic [1:0]           ResultSrcM,
   output logic [WORD_SIZE-1:0] PCTargetE,
   output logic                 PCSrcE,
   output logic                 MulBusy
);

   localparam int SHW = $clog2(WORD_SIZE);

   logic [WORD_SIZE-1:0] srcA;
   logic [WORD_SIZE-1:0] srcB;
   logic [WORD_SIZE-1:0] writeDataE;
   logic [WORD_SIZE-1:0] aluResult;
   logic                 zero;
   logic                 isMul;
   logic                 mulWrite;
   logic [WORD_SIZE-1:0] mulProduct;
   logic [WORD_SIZE-1:0] mulWriteData;
   logic [WORD_SIZE-1:0] mulPcPlus4;
   logic [EX_CTRL_W-1:0] mulCtrlBits;
   exCtrl_t              ctrlE;
   exCtrl_t              mulCtrl;

   always_comb begin
      case (ForwardAE)
         FWD_WB:  srcA = ResultW;
         FWD_MEM: srcA = ALUResultM;
         default: srcA = RD1E;
      endcase
      case (ForwardBE)
         FWD_WB:  writeDataE = ResultW;
         FWD_MEM: writeDataE = ALUResultM;
         default: writeDataE = RD2E;
      endcase
      srcB = ALUSrcE ? ImmExtE : writeDataE;
   end

   always_comb begin
      aluResult = '0;
      case (ALUControlE)
         ALU_ADD: aluResult = srcA + srcB;
         ALU_SUB: aluResult = srcA - srcB;
         ALU_AND: aluResult = srcA & srcB;
         ALU_OR:  aluResult = srcA | srcB;
         ALU_XOR: aluResult = srcA ^ srcB;
         ALU_SLT: aluResult = {{(WORD_SIZE-1){1'b0}}, $signed(srcA) < $signed(srcB)};
         ALU_SLL: aluResult = srcA << srcB[SHW-1:0];
         ALU_SRL: aluResult = srcA >> srcB[SHW-1:0];
         ALU_SRA: aluResult = $unsigned($signed(srcA) >>> srcB[SHW-1:0]);
         // MUL is produced by mul_unit, never by a combinational multiplier here
         default: aluResult = '0;
      endcase
   end

   assign zero      = (aluResult == '0);
   assign isMul     = (ALUControlE == ALU_MUL);
   assign PCTargetE = PCE + ImmExtE;
   assign PCSrcE    = !MulBusy && (JumpE || (BranchE && zero));

   assign ctrlE = '{rd: RdE, regWrite: RegWriteE, memWrite: MemWriteE,
                    byteAddress: ByteAddressE, readEnable: ReadEnableE,
                    resultSrc: ResultSrcE};
   assign mulCtrl = exCtrl_t'(mulCtrlBits);

   mul_unit #(
      .WORD_SIZE (WORD_SIZE),
      .MUL_STEP  (MUL_STEP)
   ) mulUnit (
      .clk          (clk),
      .rst          (rst),
      .isMul        (isMul),
      .flush        (FlushE),
      .stall        (StallM),
      .srcA         (srcA),
      .srcB         (srcB),
      .writeDataIn  (writeDataE),
      .pcPlus4In    (PCPlus4E),
      .ctrlIn       (ctrlE),
      .busy         (MulBusy),
      .wrProduct    (mulWrite),
      .product      (mulProduct),
      .writeDataOut (mulWriteData),
      .pcPlus4Out   (mulPcPlus4),
      .ctrlOut      (mulCtrlBits)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ALUResultM   <= '0;
         WriteDataM   <= '0;
         PCPlus4M     <= '0;
         RdM          <= '0;
         RegWriteM    <= 1'b0;
         MemWriteM    <= 1'b0;
         ByteAddressM <= 1'b0;
         ReadEnableM  <= 1'b0;
         ResultSrcM   <= '0;
      end else if (!StallM) begin
         if (mulWrite) begin
            ALUResultM   <= mulProduct;
            WriteDataM   <= mulWriteData;
            PCPlus4M     <= mulPcPlus4;
            RdM          <= mulCtrl.rd;
            RegWriteM    <= mulCtrl.regWrite;
            MemWriteM    <= mulCtrl.memWrite;
            ByteAddressM <= mulCtrl.byteAddress;
            ReadEnableM  <= mulCtrl.readEnable;
            ResultSrcM   <= mulCtrl.resultSrc;
         end else if (MulBusy || FlushE) begin
            ALUResultM   <= '0;
            WriteDataM   <= '0;
            PCPlus4M     <= '0;
            RdM          <= '0;
            RegWriteM    <= 1'b0;
            MemWriteM    <= 1'b0;
            ByteAddressM <= 1'b0;
            ReadEnableM  <= 1'b0;
            ResultSrcM   <= '0;
         end else begin
            ALUResultM   <= aluResult;
            WriteDataM   <= writeDataE;
            PCPlus4M     <= PCPlus4E;
            RdM          <= RdE;
            RegWriteM    <= RegWriteE;
            MemWriteM    <= MemWriteE;
            ByteAddressM <= ByteAddressE;
            ReadEnableM  <= ReadEnableE;
            ResultSrcM   <= ResultSrcE;
         end
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// Directed and randomized bench for execute_stage against a transaction-level model.
module tb_execute_stage;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd9;
   localparam int MUL_EDGES = 32 / 8 + 1;

   typedef struct {
      logic [31:0] alu;
      logic [31:0] wd;
      logic [31:0] pc4;
      logic [4:0]  rd;
      logic        rw;
      logic        mw;
      logic        ba;
      logic        re;
      logic [1:0]  rs;
   } exMem_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
   logic [4:0]  RdE;
   logic [3:0]  ALUControlE;
   logic        ALUSrcE, RegWriteE, MemWriteE, JumpE, BranchE, ByteAddressE, ReadEnableE;
   logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
   logic        StallM, FlushE;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M, PCTargetE;
   logic [4:0]  RdM;
   logic        RegWriteM, MemWriteM, ByteAddressM, ReadEnableM, PCSrcE, MulBusy;
   logic [1:0]  ResultSrcM;

   int nChecks = 0;
   int nFails  = 0;

   exMem_t      m;
   bit          mBubble;
   bit          mulOn;
   int          mulAge;
   logic [31:0] mulProd;
   exMem_t      mulSave;

   execute_stage #(.WORD_SIZE(32), .MUL_STEP(8)) dut (
      .clk(clk), .rst(rst), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
      .PCPlus4E(PCPlus4E), .RdE(RdE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
      .ByteAddressE(ByteAddressE), .ReadEnableE(ReadEnableE), .ResultSrcE(ResultSrcE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW), .StallM(StallM),
      .FlushE(FlushE), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .PCPlus4M(PCPlus4M), .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
      .ByteAddressM(ByteAddressM), .ReadEnableM(ReadEnableM), .ResultSrcM(ResultSrcM),
      .PCTargetE(PCTargetE), .PCSrcE(PCSrcE), .MulBusy(MulBusy)
   );

   always #5 clk = ~clk;

   task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exMem_t zeroExMem();
      exMem_t z;
      z.alu = '0; z.wd = '0; z.pc4 = '0; z.rd = '0;
      z.rw = 1'b0; z.mw = 1'b0; z.ba = 1'b0; z.re = 1'b0; z.rs = '0;
      return z;
   endfunction

   function automatic logic [31:0] fwdRef(input logic [1:0] sel, input logic [31:0] regVal,
                                          input logic [31:0] wbVal, input logic [31:0] memVal);
      case (sel)
         2'b01:   return wbVal;
         2'b10:   return memVal;
         default: return regVal;
      endcase
   endfunction

   function automatic logic [31:0] aluRef(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd6:    return a << b[4:0];
         4'd7:    return a >> b[4:0];
         4'd8:    return $unsigned($signed(a) >>> b[4:0]);
         4'd9:    return a * b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic resetModel();
      m       = zeroExMem();
      mBubble = 1'b0;
      mulOn   = 1'b0;
      mulAge  = 0;
   endtask

   task automatic clearInputs();
      RD1E = '0; RD2E = '0; ImmExtE = '0; PCE = '0; PCPlus4E = '0; ResultW = '0;
      RdE = '0; ALUControlE = OP_ADD; ALUSrcE = 0; RegWriteE = 0; MemWriteE = 0;
      JumpE = 0; BranchE = 0; ByteAddressE = 0; ReadEnableE = 0; ResultSrcE = '0;
      ForwardAE = '0; ForwardBE = '0; StallM = 0; FlushE = 0;
   endtask

   task automatic checkExMem(input string tag);
      expectEq({tag, ":RdM"}, 32'(RdM), 32'(m.rd));
      expectEq({tag, ":RegWriteM"}, 32'(RegWriteM), 32'(m.rw));
      expectEq({tag, ":MemWriteM"}, 32'(MemWriteM), 32'(m.mw));
      expectEq({tag, ":ReadEnableM"}, 32'(ReadEnableM), 32'(m.re));
      if (!mBubble) begin
         expectEq({tag, ":ALUResultM"}, ALUResultM, m.alu);
         expectEq({tag, ":WriteDataM"}, WriteDataM, m.wd);
         expectEq({tag, ":PCPlus4M"}, PCPlus4M, m.pc4);
         expectEq({tag, ":ByteAddressM"}, 32'(ByteAddressM), 32'(m.ba));
         expectEq({tag, ":ResultSrcM"}, 32'(ResultSrcM), 32'(m.rs));
      end
   endtask

   // One clock: check combinational outputs mid-cycle, predict EX/MEM, check after the edge.
   task automatic runCycle(input string tag);
      logic [31:0] a, wd, b, alu;
      logic        busy, pcs, isMul, ready, stall, flush;
      exMem_t      cur, nxt;
      bit          nxtBub;
      @(negedge clk);
      a     = fwdRef(ForwardAE, RD1E, ResultW, m.alu);
      wd    = fwdRef(ForwardBE, RD2E, ResultW, m.alu);
      b     = ALUSrcE ? ImmExtE : wd;
      alu   = aluRef(ALUControlE, a, b);
      stall = StallM;
      flush = FlushE;
      isMul = (ALUControlE == OP_MUL);
      ready = mulOn && (mulAge >= MUL_EDGES);
      busy  = mulOn ? (!ready || stall) : isMul;
      pcs   = busy ? 1'b0 : (JumpE | (BranchE & (alu == 32'd0)));
      expectEq({tag, ":MulBusy"}, 32'(MulBusy), 32'(busy));
      expectEq({tag, ":PCSrcE"}, 32'(PCSrcE), 32'(pcs));
      expectEq({tag, ":PCTargetE"}, PCTargetE, PCE + ImmExtE);
      cur.alu = alu; cur.wd = wd; cur.pc4 = PCPlus4E; cur.rd = RdE; cur.rw = RegWriteE;
      cur.mw = MemWriteE; cur.ba = ByteAddressE; cur.re = ReadEnableE; cur.rs = ResultSrcE;
      nxt    = m;
      nxtBub = mBubble;
      if (!stall) begin
         if (ready) begin
            nxt     = mulSave;
            nxt.alu = mulProd;
            nxtBub  = 1'b0;
         end else if (busy || flush) begin
            nxt    = zeroExMem();
            nxtBub = 1'b1;
         end else begin
            nxt    = cur;
            nxtBub = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      m       = nxt;
      mBubble = nxtBub;
      if (mulOn) begin
         if (ready && !stall) mulOn = 1'b0;
         else mulAge++;
      end else if (isMul && !flush && !stall) begin
         mulOn   = 1'b1;
         mulAge  = 1;
         mulProd = a * b;
         mulSave = cur;
      end
      checkExMem(tag);
   endtask

   initial begin
      int busyCnt;
      rst = 1'b0;
      clearInputs();
      resetModel();
      #12;
      checkExMem("reset");
      expectEq("reset:MulBusy", 32'(MulBusy), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // ADD with register operands
      RD1E = 32'd5; RD2E = 32'd7; RdE = 5'd3; RegWriteE = 1;
      runCycle("add");
      expectEq("add:result", ALUResultM, 32'd12);
      expectEq("add:rd", 32'(RdM), 32'd3);
      expectEq("add:regwrite", 32'(RegWriteM), 32'd1);

      // forward from EX/MEM with immediate operand
      clearInputs();
      RD1E = 32'h10; RdE = 5'd4; RegWriteE = 1;
      runCycle("fwd_setup");
      expectEq("fwd_setup:result", ALUResultM, 32'h10);
      RD1E = 32'hDEAD_BEEF; ForwardAE = 2'b10; ImmExtE = 32'd4; ALUSrcE = 1;
      runCycle("fwd_mem");
      expectEq("fwd_mem:result", ALUResultM, 32'h14);
      clearInputs();
      RD1E = 32'd1; RD2E = 32'd55; ForwardBE = 2'b01; ResultW = 32'd100;
      runCycle("fwd_wb");
      expectEq("fwd_wb:result", ALUResultM, 32'd101);
      expectEq("fwd_wb:writedata", WriteDataM, 32'd100);
      clearInputs();
      RD1E = 32'd7; RD2E = 32'd1; ForwardAE = 2'b11;
      runCycle("fwd_11");
      expectEq("fwd_11:result", ALUResultM, 32'd8);

      // branch taken / not taken
      clearInputs();
      RD1E = 32'd9; RD2E = 32'd9; ALUControlE = OP_SUB; BranchE = 1;
      PCE = 32'h100; ImmExtE = 32'h20;
      #1;
      expectEq("beq_taken:PCSrcE", 32'(PCSrcE), 32'd1);
      expectEq("beq_taken:PCTargetE", PCTargetE, 32'h120);
      runCycle("beq_taken");
      RD2E = 32'd8;
      #1;
      expectEq("beq_not:PCSrcE", 32'(PCSrcE), 32'd0);
      runCycle("beq_not");

      // flush inserts a bubble
      clearInputs();
      RD1E = 32'd3; RdE = 5'd12; RegWriteE = 1; MemWriteE = 1; FlushE = 1;
      runCycle("flush");
      expectEq("flush:regwrite", 32'(RegWriteM), 32'd0);
      expectEq("flush:rd", 32'(RdM), 32'd0);

      // multiply 0xFFFFFFFF * 3
      clearInputs();
      RD1E = 32'hFFFF_FFFF; RD2E = 32'd3; ALUControlE = OP_MUL; RdE = 5'd7; RegWriteE = 1;
      busyCnt = 0;
      for (int k = 0; k < 6; k++) begin
         #1;
         if (MulBusy) busyCnt++;
         runCycle("mul");
         if (k < 5) expectEq("mul:bubble_regwrite", 32'(RegWriteM), 32'd0);
      end
      expectEq("mul:busy_cycles", 32'(busyCnt), 32'd5);
      expectEq("mul:product", ALUResultM, 32'hFFFF_FFFD);
      expectEq("mul:rd", 32'(RdM), 32'd7);

      // StallM held during DONE
      clearInputs();
      RD1E = 32'd6; RD2E = 32'd7; ALUControlE = OP_MUL; RdE = 5'd9; RegWriteE = 1;
      for (int k = 0; k < 5; k++) runCycle("mulstall_run");
      StallM = 1;
      for (int k = 0; k < 3; k++) begin
         #1;
         expectEq("mulstall:busy_held", 32'(MulBusy), 32'd1);
         runCycle("mulstall_hold");
         expectEq("mulstall:frozen_regwrite", 32'(RegWriteM), 32'd0);
      end
      StallM = 0;
      #1;
      expectEq("mulstall:busy_release", 32'(MulBusy), 32'd0);
      runCycle("mulstall_write");
      expectEq("mulstall:product", ALUResultM, 32'd42);
      expectEq("mulstall:rd", 32'(RdM), 32'd9);

      // reset in the middle of a multiply
      clearInputs();
      RD1E = 32'd11; RD2E = 32'd13; ALUControlE = OP_MUL; RdE = 5'd5; RegWriteE = 1;
      runCycle("mulrst_start");
      runCycle("mulrst_run");
      rst = 1'b0;
      clearInputs();
      resetModel();
      #1;
      checkExMem("mulrst_async");
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      expectEq("mulrst:busy_after", 32'(MulBusy), 32'd0);
      for (int k = 0; k < 6; k++) runCycle("mulrst_after");

      // randomized traffic; a multiply in flight holds the E inputs like the hazard unit would
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!mulOn) begin
            ALUControlE = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) ALUControlE = OP_MUL;
            RD1E = $urandom;
            RD2E = ($urandom_range(0, 3) == 0) ? RD1E : $urandom;
            ImmExtE = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
            PCE = $urandom;
            PCPlus4E = PCE + 32'd4;
            RdE = 5'($urandom);
            ALUSrcE = 1'($urandom);
            RegWriteE = 1'($urandom);
            MemWriteE = 1'($urandom);
            ByteAddressE = 1'($urandom);
            ReadEnableE = 1'($urandom);
            ResultSrcE = 2'($urandom);
            ForwardAE = 2'($urandom);
            ForwardBE = 2'($urandom);
            if (mBubble && ForwardAE == 2'b10) ForwardAE = 2'b00;
            if (mBubble && ForwardBE == 2'b10) ForwardBE = 2'b00;
            BranchE = (ALUControlE == OP_MUL) ? 1'b0 : 1'($urandom);
            JumpE = (ALUControlE == OP_MUL) ? 1'b0 : ($urandom_range(0, 7) == 0);
         end
         ResultW = $urandom;
         StallM = ($urandom_range(0, 4) == 0);
         FlushE = ($urandom_range(0, 5) == 0);
         runCycle("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
